// File: rtl/hash_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// hash_dispatch_pkg
// Shared constants and types for the hash PE request dispatcher slice.
// The constants are the default configuration. Modules take them as parameter
// defaults, so a smaller build can override them per instance.
// Optional feature macro used by this slice: HASH_DISPATCH_BCAST_EN.
// -----------------------------------------------------------------------------
package hash_dispatch_pkg;

    localparam int ISSUE_W     = 16;  // hash requests per issue window
    localparam int HASH_BITS   = 15;  // full hash width
    localparam int NUM_PE_LOG2 = 4;   // log2 of hash PE count
    localparam int ADDR_W      = 32;  // byte address width
    localparam int NUM_PE      = 1 << NUM_PE_LOG2;
    localparam int STRIP_BITS  = HASH_BITS - NUM_PE_LOG2;

    typedef logic [ISSUE_W-1:0]    lane_mask_t;   // one lane's slot mask
    typedef logic [STRIP_BITS-1:0] strip_word_t;  // hash with PE index removed

    // EMPTY: no window buffered. HOLD: a window is waiting on lane handshakes.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/hash_pe_request_dispatcher_if.sv
// -----------------------------------------------------------------------------
// hash_pe_request_dispatcher_if
// Bundles the upstream issue-window handshake and the per-lane downstream
// handshakes of the dispatcher.
//   slave  : dispatcher side (consumes in_*, out_ready; drives in_ready, out_*)
//   master : environment side (the opposite directions)
// -----------------------------------------------------------------------------
interface hash_pe_request_dispatcher_if #(
    parameter int ISSUE_W     = hash_dispatch_pkg::ISSUE_W,
    parameter int HASH_BITS   = hash_dispatch_pkg::HASH_BITS,
    parameter int NUM_PE_LOG2 = hash_dispatch_pkg::NUM_PE_LOG2,
    parameter int ADDR_W      = hash_dispatch_pkg::ADDR_W
);
    localparam int NUM_PE     = 1 << NUM_PE_LOG2;
    localparam int STRIP_BITS = HASH_BITS - NUM_PE_LOG2;

    logic                          in_valid;
    logic                          in_ready;
    logic [ADDR_W-1:0]             in_head_addr;
    logic [ISSUE_W-1:0]            in_mask_vec;
    logic [ISSUE_W*HASH_BITS-1:0]  in_hash_vec;
    logic                          in_delim;

    logic [NUM_PE-1:0]             out_valid;
    logic [NUM_PE-1:0]             out_ready;
    logic [ADDR_W-1:0]             out_head_addr;
    logic [NUM_PE*ISSUE_W-1:0]     out_mask_vec;
    logic [ISSUE_W*STRIP_BITS-1:0] out_hash_vec;
    logic                          out_delim;

    modport slave (
        input  in_valid, in_head_addr, in_mask_vec, in_hash_vec, in_delim, out_ready,
        output in_ready, out_valid, out_head_addr, out_mask_vec, out_hash_vec, out_delim
    );

    modport master (
        output in_valid, in_head_addr, in_mask_vec, in_hash_vec, in_delim, out_ready,
        input  in_ready, out_valid, out_head_addr, out_mask_vec, out_hash_vec, out_delim
    );

endinterface

// File: rtl/hash_lane_splitter.sv
// -----------------------------------------------------------------------------
// hash_lane_splitter
// Purely combinational split of an issue window. Each slot's low NUM_PE_LOG2
// hash bits select its PE lane. The remaining high bits form the stripped hash.
// Ports:
//   mask_vec      in  per-slot request valid
//   hash_vec      in  slot i at [i*HASH_BITS +: HASH_BITS]
//   lane_mask_vec out lane p mask at [p*ISSUE_W +: ISSUE_W]
//   strip_vec     out slot i at [i*STRIP_BITS +: STRIP_BITS]
// -----------------------------------------------------------------------------
module hash_lane_splitter #(
    parameter int ISSUE_W     = hash_dispatch_pkg::ISSUE_W,
    parameter int HASH_BITS   = hash_dispatch_pkg::HASH_BITS,
    parameter int NUM_PE_LOG2 = hash_dispatch_pkg::NUM_PE_LOG2
) (
    input  logic [ISSUE_W-1:0]                                   mask_vec,
    input  logic [ISSUE_W*HASH_BITS-1:0]                         hash_vec,
    output logic [(1<<NUM_PE_LOG2)*ISSUE_W-1:0]                  lane_mask_vec,
    output logic [ISSUE_W*(HASH_BITS-NUM_PE_LOG2)-1:0]           strip_vec
);
    localparam int NUM_PE     = 1 << NUM_PE_LOG2;
    localparam int STRIP_BITS = HASH_BITS - NUM_PE_LOG2;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        lane_mask_vec = '0;
        strip_vec     = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            strip_vec[i*STRIP_BITS +: STRIP_BITS] = hash_vec[i*HASH_BITS + NUM_PE_LOG2 +: STRIP_BITS];
            for (int p = 0; p < NUM_PE; p++) begin
                lane_mask_vec[p*ISSUE_W + i] = mask_vec[i] &
                    (hash_vec[i*HASH_BITS +: NUM_PE_LOG2] == NUM_PE_LOG2'(p));
            end
        end
    end

endmodule

// File: rtl/hash_pe_request_dispatcher.sv
// -----------------------------------------------------------------------------
// hash_pe_request_dispatcher
// Takes one issue window per cycle. It splits the window into per-PE lane masks
// and stripped hashes, then forks the window to NUM_PE serializer lanes. The
// window stays in a single buffer stage until every lane that needs it has
// handshaked. Each lane handshakes independently. A stalled lane only holds
// back the next window.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         hash_pe_request_dispatcher_if.slave (issue window in, lanes out)
// Optional feature: HASH_DISPATCH_BCAST_EN. When defined, a delim window is
// offered to every lane, including lanes with no requests, so that each
// serializer sees the block boundary.
// -----------------------------------------------------------------------------
module hash_pe_request_dispatcher #(
    parameter int ISSUE_W     = hash_dispatch_pkg::ISSUE_W,
    parameter int HASH_BITS   = hash_dispatch_pkg::HASH_BITS,
    parameter int NUM_PE_LOG2 = hash_dispatch_pkg::NUM_PE_LOG2,
    parameter int ADDR_W      = hash_dispatch_pkg::ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hash_pe_request_dispatcher_if.slave    bus
);
    import hash_dispatch_pkg::*;

    localparam int LANES = 1 << NUM_PE_LOG2;
    localparam int SBITS = HASH_BITS - NUM_PE_LOG2;

    disp_state_t                state_q, state_d;
    logic [LANES-1:0]           sent_q, sent_d;
    logic [LANES-1:0]           need, out_valid, lane_hs;
    logic                       buf_valid, all_done, in_ready, accept, in_any, load;

    logic [LANES*ISSUE_W-1:0]   split_mask;
    logic [ISSUE_W*SBITS-1:0]   split_strip;
    logic [ADDR_W-1:0]          head_q;
    logic [LANES*ISSUE_W-1:0]   mask_q;
    logic [ISSUE_W*SBITS-1:0]   strip_q;
    logic                       delim_q;

    hash_lane_splitter #(
        .ISSUE_W     (ISSUE_W),
        .HASH_BITS   (HASH_BITS),
        .NUM_PE_LOG2 (NUM_PE_LOG2)
    ) u_splitter (
        .mask_vec      (bus.in_mask_vec),
        .hash_vec      (bus.in_hash_vec),
        .lane_mask_vec (split_mask),
        .strip_vec     (split_strip)
    );

    // A lane needs the buffered window if it carries at least one request.
    always_comb begin
        need = '0;
        for (int p = 0; p < LANES; p++) begin
`ifdef HASH_DISPATCH_BCAST_EN
            need[p] = (|mask_q[p*ISSUE_W +: ISSUE_W]) | delim_q;
`else
            need[p] = |mask_q[p*ISSUE_W +: ISSUE_W];
`endif
        end
    end

`ifdef HASH_DISPATCH_BCAST_EN
    assign in_any = (|bus.in_mask_vec) | bus.in_delim;
`else
    assign in_any = |bus.in_mask_vec;
`endif

    assign buf_valid = (state_q == ST_HOLD);
    assign out_valid = buf_valid ? (need & ~sent_q) : '0;
    assign lane_hs   = out_valid & bus.out_ready;
    // A lane is finished when it has handshaked earlier, does not need this
    // window, or is handshaking now. Counting the current handshake gives the
    // intentional combinational path from out_ready to in_ready.
    assign all_done  = &(sent_q | ~need | lane_hs);
    assign in_ready  = rst_n & (~buf_valid | all_done);
    assign accept    = bus.in_valid & in_ready;
    // A window with nothing to offer is consumed without occupying the buffer.
    assign load      = accept & in_any;

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_HOLD;
                    sent_d  = '0;
                end
            end
            ST_HOLD: begin
                if (all_done) begin
                    sent_d  = '0;
                    state_d = load ? ST_HOLD : ST_EMPTY;
                end else begin
                    sent_d  = sent_q | lane_hs;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                sent_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
        end
    end

    // NOTE: the payload registers have no reset. They are only read while
    // buf_valid is set, and reset clears buf_valid.
    always_ff @(posedge clk) begin
        if (load) begin
            head_q  <= bus.in_head_addr;
            mask_q  <= split_mask;
            strip_q <= split_strip;
            delim_q <= bus.in_delim;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_head_addr = head_q;
    assign bus.out_mask_vec  = mask_q;
    assign bus.out_hash_vec  = strip_q;
    assign bus.out_delim     = delim_q;

endmodule

// File: tb/tb_hash_pe_request_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_hash_pe_request_dispatcher
// Directed bench for the dispatcher in a small configuration:
// ISSUE_W=4, HASH_BITS=8, NUM_PE_LOG2=2 (four lanes, 6-bit stripped hashes).
// Inputs change on the falling clock edge. Outputs are sampled on the falling
// edge or shortly after an input change. Expectations differ when the build
// defines HASH_DISPATCH_BCAST_EN.
// -----------------------------------------------------------------------------
module tb_hash_pe_request_dispatcher;

    localparam int IW = 4;
    localparam int HB = 8;
    localparam int PL = 2;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hash_pe_request_dispatcher_if #(
        .ISSUE_W(IW), .HASH_BITS(HB), .NUM_PE_LOG2(PL), .ADDR_W(AW)
    ) bus ();

    hash_pe_request_dispatcher #(
        .ISSUE_W(IW), .HASH_BITS(HB), .NUM_PE_LOG2(PL), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // hash is packed slot3..slot0, one byte per slot.
    task automatic drive(input logic v, input logic [3:0] m, input logic [31:0] h,
                         input logic d, input logic [31:0] a);
        bus.in_valid     = v;
        bus.in_mask_vec  = m;
        bus.in_hash_vec  = h;
        bus.in_delim     = d;
        bus.in_head_addr = a;
    endtask

    // Expected values, worked out by hand.
    // W1 hashes slot3..0 = 13,22,31,40 -> pe 3,2,1,0; stripped 04,08,0C,10.
    localparam logic [31:0] W1_HASH  = 32'h13223140;
    localparam logic [15:0] W1_MASKS = 16'h8421;  // lane3..0 = 1000,0100,0010,0001
    // W2 hashes slot3..0 = FF,02,2D,05, mask 0011 -> slots 0,1 both pe 1.
    // 2D = 0010_1101 -> strip 0B; 05 -> strip 01; FF -> 3F; 02 -> 00.
    localparam logic [31:0] W2_HASH  = 32'hFF022D05;
    localparam logic [15:0] W2_MASKS = 16'h0030;  // lane1 = 0011

    logic [23:0] w1_strip;
    logic [23:0] w2_strip;
    logic [23:0] exp_strip;
    logic [31:0] h;
    int          n_out;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w1_strip = {6'h04, 6'h08, 6'h0C, 6'h10};
        w2_strip = {6'h3F, 6'h00, 6'h0B, 6'h01};
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        bus.out_ready = 4'h0;

        // Reset state
        #2;
        check("rst_out_valid", bus.out_valid, 4'h0);
        check("rst_in_ready",  bus.in_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // 1. Basic split, all lanes ready
        drive(1'b1, 4'b1111, W1_HASH, 1'b0, 32'h0000_1000);
        bus.out_ready = 4'b1111;
        #1;
        check("t1_in_ready_empty", bus.in_ready, 1'b1);
        @(negedge clk);
        check("t1_out_valid", bus.out_valid,     4'b1111);
        check("t1_masks",     bus.out_mask_vec,  W1_MASKS);
        check("t1_strip",     bus.out_hash_vec,  w1_strip);
        check("t1_addr",      bus.out_head_addr, 32'h0000_1000);
        check("t1_delim",     bus.out_delim,     1'b0);
        check("t1_in_ready",  bus.in_ready,      1'b1);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t1_drained", bus.out_valid, 4'h0);

        // 2. Lane 2 stalls for three cycles; W2 waits at the input
        drive(1'b1, 4'b1111, W1_HASH, 1'b0, 32'h0000_1100);
        bus.out_ready = 4'b1011;
        @(negedge clk);
        check("t2_out_valid_c1", bus.out_valid, 4'b1111);
        check("t2_in_ready_c1",  bus.in_ready,  1'b0);
        drive(1'b1, 4'b0011, W2_HASH, 1'b1, 32'h0000_2000);
        @(negedge clk);
        check("t2_out_valid_c2", bus.out_valid, 4'b0100);
        check("t2_in_ready_c2",  bus.in_ready,  1'b0);
        @(negedge clk);
        check("t2_out_valid_c3", bus.out_valid,     4'b0100);
        check("t2_in_ready_c3",  bus.in_ready,      1'b0);
        check("t2_addr_stable",  bus.out_head_addr, 32'h0000_1100);
        check("t2_masks_stable", bus.out_mask_vec,  W1_MASKS);
        bus.out_ready = 4'b1111;
        #1;
        check("t2_in_ready_release", bus.in_ready, 1'b1);

        // 3. Empty lanes: W2 is taken on the same edge that lane 2 completes
        @(negedge clk);
`ifdef HASH_DISPATCH_BCAST_EN
        check("t3_out_valid", bus.out_valid, 4'b1111);
`else
        check("t3_out_valid", bus.out_valid, 4'b0010);
`endif
        check("t3_masks", bus.out_mask_vec,  W2_MASKS);
        check("t3_strip", bus.out_hash_vec,  w2_strip);
        check("t3_addr",  bus.out_head_addr, 32'h0000_2000);
        check("t3_delim", bus.out_delim,     1'b1);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t3_drained", bus.out_valid, 4'h0);

        // 4. Eight back-to-back windows. Slot i of window k has pe=i, strip=k+i.
        n_out = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                exp_strip = {6'(k+2), 6'(k+1), 6'(k), 6'(k-1)};
                check($sformatf("t4_w%0d_valid", k-1), bus.out_valid,     4'b1111);
                check($sformatf("t4_w%0d_strip", k-1), bus.out_hash_vec,  exp_strip);
                check($sformatf("t4_w%0d_addr",  k-1), bus.out_head_addr, 32'h4000 + 32'(k-1));
                if (bus.out_valid == 4'b1111) n_out++;
            end
            if (k < 8) begin
                for (int i = 0; i < IW; i++) h[i*8 +: 8] = {6'(k+i), 2'(i)};
                drive(1'b1, 4'b1111, h, 1'b0, 32'h4000 + 32'(k));
                #1;
                check($sformatf("t4_in_ready_%0d", k), bus.in_ready, 1'b1);
            end else begin
                drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
            end
            @(negedge clk);
        end
        check("t4_windows_out", 64'(n_out), 64'd8);
        check("t4_drained", bus.out_valid, 4'h0);

        // 5. Asynchronous reset while lane 3 is stalled
        drive(1'b1, 4'b1111, W1_HASH, 1'b0, 32'h0000_5000);
        bus.out_ready = 4'b0111;
        @(negedge clk);
        check("t5_out_valid_c1", bus.out_valid, 4'b1111);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5_out_valid_c2", bus.out_valid, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", bus.out_valid, 4'h0);
        check("t5_rst_in_ready",  bus.in_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, W1_HASH, 1'b0, 32'h0000_5100);
        bus.out_ready = 4'b1111;
        @(negedge clk);
        check("t5_post_valid", bus.out_valid,     4'b1111);
        check("t5_post_masks", bus.out_mask_vec,  W1_MASKS);
        check("t5_post_addr",  bus.out_head_addr, 32'h0000_5100);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);

        // 6. All-zero-mask delim window
        drive(1'b1, 4'b0000, W1_HASH, 1'b1, 32'h0000_6000);
        #1;
        check("t6_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
`ifdef HASH_DISPATCH_BCAST_EN
        check("t6_out_valid", bus.out_valid,    4'b1111);
        check("t6_masks",     bus.out_mask_vec, 16'h0000);
        check("t6_delim",     bus.out_delim,    1'b1);
`else
        check("t6_out_valid", bus.out_valid, 4'h0);
`endif
        #1;
        check("t6_in_ready_after", bus.in_ready, 1'b1);
        @(negedge clk);
        check("t6_drained", bus.out_valid, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
